// File: rtl/alu_req_arbiter_if.sv
// Bundles the two request ports, the external ALU connection and the response port.
// The arbiter connects through the slave modport; the requesters/consumer/ALU side uses master.
interface alu_req_arbiter_if #(
    parameter int WIDTH = 16
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic [3:0]       req0_sel;

    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic [3:0]       req1_sel;

    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [3:0]       alu_sel;
    logic [WIDTH-1:0] alu_y;
    logic             alu_cout;
    logic             alu_zero;

    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [WIDTH-1:0] rsp_y;
    logic             rsp_cout;
    logic             rsp_zero;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_sel,
        input  req1_valid, req1_a, req1_b, req1_sel,
        input  alu_y, alu_cout, alu_zero, rsp_ready,
        output req0_ready, req1_ready,
        output alu_a, alu_b, alu_sel,
        output rsp_valid, rsp_id, rsp_y, rsp_cout, rsp_zero
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_sel,
        output req1_valid, req1_a, req1_b, req1_sel,
        output alu_y, alu_cout, alu_zero, rsp_ready,
        input  req0_ready, req1_ready,
        input  alu_a, alu_b, alu_sel,
        input  rsp_valid, rsp_id, rsp_y, rsp_cout, rsp_zero
    );
endinterface

// File: rtl/alu_req_arbiter.sv
// Round-robin arbiter sharing one external combinational ALU between two requesters.
// Handshake: a transfer happens on a rising edge where valid && ready; ready never depends on ready of the other side.
module alu_req_arbiter #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_req_arbiter_if.slave bus,
    output logic             busy,
    output logic [CNT_W-1:0] op_count,
    output logic [1:0]       state_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             last_grant_q;
    logic [WIDTH-1:0] alu_a_q, alu_b_q;
    logic [3:0]       alu_sel_q;
    logic             rsp_valid_q, rsp_id_q, rsp_cout_q, rsp_zero_q;
    logic [WIDTH-1:0] rsp_y_q;
    logic [CNT_W-1:0] op_count_q;

    logic             grant;
    logic             accept;
    logic [WIDTH-1:0] grant_a, grant_b;
    logic [3:0]       grant_sel;

    // Unary opcodes ignore B; forcing it to zero keeps undriven operands off the ALU.
    function automatic logic is_unary(input logic [3:0] sel);
        case (sel)
            4'b0010, 4'b0011, 4'b0111,
            4'b1000, 4'b1001, 4'b1010, 4'b1011, 4'b1100: is_unary = 1'b1;
            default:                                     is_unary = 1'b0;
        endcase
    endfunction

    always_comb begin
        grant = 1'b0;
        if (bus.req0_valid && bus.req1_valid) grant = ~last_grant_q;
        else if (bus.req1_valid)              grant = 1'b1;
        accept    = (state_q == IDLE) && (bus.req0_valid || bus.req1_valid);
        grant_a   = grant ? bus.req1_a   : bus.req0_a;
        grant_b   = grant ? bus.req1_b   : bus.req0_b;
        grant_sel = grant ? bus.req1_sel : bus.req0_sel;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    if (bus.rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.req0_ready = (state_q == IDLE) && !grant && bus.req0_valid;
        bus.req1_ready = (state_q == IDLE) &&  grant && bus.req1_valid;
        busy           = (state_q != IDLE);
        state_o        = state_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= 1'b1;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_sel_q    <= 4'b1111;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_y_q      <= '0;
            rsp_cout_q   <= 1'b0;
            rsp_zero_q   <= 1'b0;
            op_count_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        alu_a_q      <= grant_a;
                        alu_b_q      <= is_unary(grant_sel) ? '0 : grant_b;
                        alu_sel_q    <= grant_sel;
                        rsp_id_q     <= grant;
                        last_grant_q <= grant;
                    end
                end
                EXEC: begin
                    rsp_y_q     <= bus.alu_y;
                    rsp_cout_q  <= bus.alu_cout;
                    rsp_zero_q  <= bus.alu_zero;
                    rsp_valid_q <= 1'b1;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        op_count_q  <= op_count_q + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.alu_a     = alu_a_q;
    assign bus.alu_b     = alu_b_q;
    assign bus.alu_sel   = alu_sel_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_y     = rsp_y_q;
    assign bus.rsp_cout  = rsp_cout_q;
    assign bus.rsp_zero  = rsp_zero_q;
    assign op_count      = op_count_q;

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Directed bench for alu_req_arbiter: a behavioural ALU, request/response driver tasks,
// an expected-response queue, and a second small-counter instance for the wrap case.
module tb_alu_req_arbiter;

  logic        clk;
  logic        rst_n;
  logic        busy, busy2;
  logic [15:0] op_count;
  logic [1:0]  op_count2;
  logic [1:0]  state_dbg, state_dbg2;

  int n_total = 0;
  int n_bad   = 0;

  // {rsp_id, rsp_cout, rsp_zero, rsp_y}
  logic [18:0] exp_q[$];

  alu_req_arbiter_if #(.WIDTH(16)) bus ();
  alu_req_arbiter_if #(.WIDTH(16)) bus2 ();

  alu_req_arbiter #(.WIDTH(16), .CNT_W(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .busy     (busy),
    .op_count (op_count),
    .state_o  (state_dbg)
  );

  alu_req_arbiter #(.WIDTH(16), .CNT_W(2)) dut2 (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus2),
    .busy     (busy2),
    .op_count (op_count2),
    .state_o  (state_dbg2)
  );

  // External ALU stand-in: returns {cout, zero, y}
  function automatic logic [17:0] alu_f(input logic [15:0] a, input logic [15:0] b,
                                        input logic [3:0] s);
    logic [16:0] r;
    case (s)
      4'b0000: r = {1'b0, a} + {1'b0, b};
      4'b0001: r = {1'b0, a} - {1'b0, b};
      4'b0010: r = {1'b0, a} + 17'd1;
      4'b0011: r = {1'b0, a} - 17'd1;
      4'b0100: r = {1'b0, a & b};
      4'b0101: r = {1'b0, a | b};
      4'b0110: r = {1'b0, a ^ b};
      4'b0111: r = {1'b0, ~a};
      4'b1000: r = {a, 1'b0};
      4'b1001: r = {a[0], 1'b0, a[15:1]};
      4'b1010: r = {1'b0, a[14:0], a[15]};
      4'b1011: r = {1'b0, a[0], a[15:1]};
      4'b1100: r = {1'b0, a};
      default: r = {1'b0, b};
    endcase
    return {r[16], (r[15:0] == 16'h0000), r[15:0]};
  endfunction

  assign {bus.alu_cout, bus.alu_zero, bus.alu_y}    = alu_f(bus.alu_a, bus.alu_b, bus.alu_sel);
  assign {bus2.alu_cout, bus2.alu_zero, bus2.alu_y} = alu_f(bus2.alu_a, bus2.alu_b, bus2.alu_sel);

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Present an operation on one port and hold it until the handshake edge.
  // Returns at the falling edge after the accept edge (the arbiter is then in EXEC).
  task automatic issue(input bit id, input logic [15:0] a, input logic [15:0] b,
                       input logic [3:0] sel);
    bit done;
    done = 1'b0;
    @(negedge clk);
    if (id == 1'b0) begin
      bus.req0_valid = 1'b1; bus.req0_a = a; bus.req0_b = b; bus.req0_sel = sel;
    end else begin
      bus.req1_valid = 1'b1; bus.req1_a = a; bus.req1_b = b; bus.req1_sel = sel;
    end
    for (int i = 0; i < 30 && !done; i++) begin
      #1;
      if ((id == 1'b0 && bus.req0_ready) || (id == 1'b1 && bus.req1_ready)) done = 1'b1;
      else @(negedge clk);
    end
    check("accept", 32'(done), 32'd1);
    @(posedge clk);
    @(negedge clk);
    if (id == 1'b0) bus.req0_valid = 1'b0;
    else            bus.req1_valid = 1'b0;
  endtask

  // Wait (bounded) for a response, compare it against the queue head, then accept it.
  task automatic collect(input string tag);
    bit          seen;
    logic [18:0] exp, got;
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      if (bus.rsp_valid) seen = 1'b1;
      else @(negedge clk);
    end
    check({tag, "_seen"}, 32'(seen), 32'd1);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 19'h7ffff;
    got = {bus.rsp_id, bus.rsp_cout, bus.rsp_zero, bus.rsp_y};
    check(tag, 32'(got), 32'(exp));
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.rsp_ready = 1'b0;
  endtask

  initial begin
    int          n_g, n_r;
    bit          stop_req;
    logic [18:0] exp, got;

    rst_n = 1'b0;
    bus.req0_valid = 0; bus.req0_a = 0; bus.req0_b = 0; bus.req0_sel = 0;
    bus.req1_valid = 0; bus.req1_a = 0; bus.req1_b = 0; bus.req1_sel = 0;
    bus.rsp_ready  = 0;
    bus2.req0_valid = 0; bus2.req0_a = 0; bus2.req0_b = 0; bus2.req0_sel = 0;
    bus2.req1_valid = 0; bus2.req1_a = 0; bus2.req1_b = 0; bus2.req1_sel = 0;
    bus2.rsp_ready  = 0;

    // reset values
    repeat (3) @(negedge clk);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_busy",      32'(busy),          32'd0);
    check("rst_alu_sel",   32'(bus.alu_sel),   32'hF);
    check("rst_alu_a",     32'(bus.alu_a),     32'h0);
    check("rst_alu_b",     32'(bus.alu_b),     32'h0);
    check("rst_rsp",       32'({bus.rsp_id, bus.rsp_cout, bus.rsp_zero, bus.rsp_y}), 32'h0);
    check("rst_op_count",  32'(op_count),      32'd0);
    rst_n = 1'b1;

    // single operation: 5 + 3
    exp_q.push_back({1'b0, 1'b0, 1'b0, 16'h0008});
    issue(1'b0, 16'h0005, 16'h0003, 4'b0000);
    check("single_busy",     32'(busy),          32'd1);
    check("single_valid_t1", 32'(bus.rsp_valid), 32'd0);
    check("single_alu_a",    32'(bus.alu_a),     32'h0005);
    check("single_alu_b",    32'(bus.alu_b),     32'h0003);
    check("single_alu_sel",  32'(bus.alu_sel),   32'h0);
    @(negedge clk);
    check("single_valid_t2", 32'(bus.rsp_valid), 32'd1);
    collect("single_rsp");
    check("single_op_count", 32'(op_count), 32'd1);
    check("single_idle",     32'(busy),     32'd0);

    // reset while in EXEC drops the operation
    issue(1'b0, 16'h0001, 16'h0001, 4'b0000);
    check("midrst_in_exec", 32'(bus.rsp_valid), 32'd0);
    rst_n = 1'b0;
    #1;
    check("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("midrst_busy",      32'(busy),          32'd0);
    check("midrst_alu_sel",   32'(bus.alu_sel),   32'hF);
    check("midrst_op_count",  32'(op_count),      32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // contention: both valid; grants must alternate 0,1,0,1 starting with requester 0
    exp_q.push_back({1'b0, 1'b0, 1'b0, 16'h0006});
    exp_q.push_back({1'b1, 1'b0, 1'b0, 16'h5A5A});
    exp_q.push_back({1'b0, 1'b0, 1'b0, 16'h0006});
    exp_q.push_back({1'b1, 1'b0, 1'b0, 16'h5A5A});
    @(negedge clk);
    bus.req0_valid = 1; bus.req0_a = 16'h000A; bus.req0_b = 16'h0004; bus.req0_sel = 4'b0001;
    bus.req1_valid = 1; bus.req1_a = 16'hF0F0; bus.req1_b = 16'hAAAA; bus.req1_sel = 4'b0110;
    bus.rsp_ready  = 1;
    n_g = 0; n_r = 0; stop_req = 1'b0;
    for (int cyc = 0; cyc < 60 && n_r < 4; cyc++) begin
      #1;
      if (stop_req) begin
        bus.req0_valid = 0;
        bus.req1_valid = 0;
      end else if (bus.req0_ready || bus.req1_ready) begin
        check($sformatf("cont_onehot%0d", n_g), 32'(bus.req0_ready & bus.req1_ready), 32'd0);
        check($sformatf("cont_grant%0d", n_g), 32'(bus.req1_ready), 32'(n_g % 2));
        n_g++;
        if (n_g == 4) stop_req = 1'b1;
      end
      if (bus.rsp_valid) begin
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 19'h7ffff;
        got = {bus.rsp_id, bus.rsp_cout, bus.rsp_zero, bus.rsp_y};
        check($sformatf("cont_rsp%0d", n_r), 32'(got), 32'(exp));
        n_r++;
      end
      @(negedge clk);
    end
    check("cont_rsp_count", 32'(n_r), 32'd4);
    bus.rsp_ready = 0;
    check("cont_op_count", 32'(op_count), 32'd4);

    // backpressure: req1 increments FFFF while the consumer stalls for 5 cycles
    exp_q.push_back({1'b1, 1'b1, 1'b1, 16'h0000});
    issue(1'b1, 16'hFFFF, 16'h1234, 4'b0010);
    bus.req0_valid = 1; bus.req0_a = 16'hAAAA; bus.req0_b = 16'hxxxx; bus.req0_sel = 4'b0111;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      #1;
      check($sformatf("bp_valid%0d", i), 32'(bus.rsp_valid), 32'd1);
      check($sformatf("bp_hold%0d", i),
            32'({bus.rsp_id, bus.rsp_cout, bus.rsp_zero, bus.rsp_y}), 32'({1'b1, 1'b1, 1'b1, 16'h0000}));
      check($sformatf("bp_req0_ready%0d", i), 32'(bus.req0_ready), 32'd0);
      @(negedge clk);
    end
    collect("bp_rsp");
    #1;
    check("bp_done_valid",  32'(bus.rsp_valid),  32'd0);
    check("bp_done_count",  32'(op_count),       32'd5);
    check("bp_req0_ready",  32'(bus.req0_ready), 32'd1);

    // unary masking: the waiting req0 NOT is accepted at the next edge
    exp_q.push_back({1'b0, 1'b0, 1'b0, 16'h5555});
    @(posedge clk);
    @(negedge clk);
    bus.req0_valid = 0;
    bus.req0_b     = 16'h0000;
    check("unary_alu_b",   32'(bus.alu_b),   32'h0000);
    check("unary_alu_a",   32'(bus.alu_a),   32'hAAAA);
    check("unary_alu_sel", 32'(bus.alu_sel), 32'h7);
    collect("unary_rsp");
    check("unary_op_count", 32'(op_count), 32'd6);

    // counter wrap on the CNT_W=2 instance: 1, 2, 3, 0, 1
    @(negedge clk);
    bus2.req0_valid = 1; bus2.req0_a = 16'h0001; bus2.req0_b = 16'h0002; bus2.req0_sel = 4'b0000;
    bus2.rsp_ready  = 1;
    for (int k = 1; k <= 5; k++) begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
        if (bus2.rsp_valid) seen = 1'b1;
        else @(negedge clk);
      end
      check($sformatf("wrap_seen%0d", k), 32'(seen), 32'd1);
      check($sformatf("wrap_y%0d", k), 32'(bus2.rsp_y), 32'h0003);
      @(negedge clk);
      check($sformatf("wrap_count%0d", k), 32'(op_count2), 32'(k % 4));
    end
    bus2.req0_valid = 0;
    bus2.rsp_ready  = 0;

    check("queue_empty", 32'(exp_q.size()), 32'd0);

    // final report
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_req_arbiter.md
Name: alu_req_arbiter

Overview:
- Shares one combinational 16-bit ALU between two requesters.
- Round-robin arbitration with a valid/ready handshake on each request port.
- Drives the ALU operand and select inputs from registers, captures Y/cout/zero, and returns them on a single response port tagged with the requester ID under a valid/ready handshake.
- Sits between the two issuing engines and the ALU instance. The ALU stays external and combinational.

Parameters:
- WIDTH, 16, operand/result width; must match the ALU.
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req0_valid  input  1  requester 0 has an operation.
- req0_ready  output  1  requester 0 operation accepted this cycle.
- req0_a, req0_b  input  WIDTH  requester 0 operands.
- req0_sel  input  4  requester 0 ALU opcode.
- req1_valid, req1_ready, req1_a, req1_b, req1_sel: same for requester 1.
- alu_a, alu_b  output  WIDTH  registered ALU operands.
- alu_sel  output  4  registered ALU select.
- alu_y  input  WIDTH  ALU result.
- alu_cout  input  1  ALU carry/borrow.
- alu_zero  input  1  ALU zero flag.
- rsp_valid  output  1  response available.
- rsp_ready  input  1  consumer accepts response.
- rsp_id  output  1  requester that issued the operation.
- rsp_y  output  WIDTH  captured result.
- rsp_cout  output  1  captured carry.
- rsp_zero  output  1  captured zero flag.
- busy  output  1  state != IDLE.
- op_count  output  CNT_W  completed responses, wraps.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, last_grant=1 (so requester 0 wins first), alu_a=alu_b=0, alu_sel=4'b1111, rsp_valid=0, rsp_id=0, rsp_y=0, rsp_cout=0, rsp_zero=0, op_count=0. req*_ready are combinational and therefore 0 outside IDLE.
- FSM states: IDLE, EXEC, RESP.
- IDLE, grant (combinational):
  - Only one valid: grant to it.
  - Both valid: grant to !last_grant.
  - reqN_ready = (state==IDLE) && grant==N && reqN_valid.
  - On a handshake edge: alu_a<=reqN_a; alu_sel<=reqN_sel; alu_b<=reqN_b, or 0 for unary opcodes 0010, 0011, 0111, 1000-1100 (masks X on B); rsp_id<=N; last_grant<=N; ->EXEC.
- EXEC (exactly 1 cycle): at the edge, rsp_y<=alu_y, rsp_cout<=alu_cout, rsp_zero<=alu_zero, rsp_valid<=1; ->RESP. ALU inputs are held stable throughout EXEC and RESP.
- RESP:
  - rsp_* are held stable while rsp_valid && !rsp_ready.
  - On an rsp_ready edge: rsp_valid<=0, op_count<=op_count+1 (wraps 2^CNT_W-1 -> 0), ->IDLE.
- Latency and throughput:
  - Accept edge T -> rsp_valid high after edge T+1.
  - Minimum 3 cycles per operation (IDLE, EXEC, RESP with rsp_ready=1).
  - No new request is accepted in RESP.
- Opcode handling: opcodes are passed unchanged; all 16 encodings are legal; no opcode decoding beyond the unary-B masking.
- Request-side rules:
  - A requester deasserting valid while not granted is legal and is ignored.
  - Operands are sampled only on the handshake edge.
- Reset mid-operation: an in-flight operation is dropped, no response is produced, and op_count is unchanged beyond the reset to 0.
- Simultaneous events: rsp_ready asserted in EXEC is ignored, since rsp_valid is still 0.

Test Plan:
- Single op: req0 A=0005 B=0003 Sel=0000 -> rsp_valid two edges after accept; rsp_y=0008, cout=0, zero=0, rsp_id=0, op_count=1.
- Contention: both valid continuously; req0 Sel=0001 A=000A B=0004; req1 Sel=0110 A=F0F0 B=AAAA -> grants alternate 0,1,0,1. Responses alternate 0006 (id0) and 5A5A (id1). No requester is granted twice in a row.
- Backpressure: req1 Sel=0010 A=FFFF with rsp_ready=0 for 5 cycles -> rsp_y=0000, cout=1, zero=1 held stable; req0_ready=0 throughout; completes one cycle after rsp_ready=1.
- Unary masking: req0 Sel=0111 A=AAAA B=xxxx -> alu_b=0000 (no X); rsp_y=5555.
- Reset mid-op: assert rst_n=0 during EXEC -> immediately rsp_valid=0, busy=0, alu_sel=1111, op_count=0. After release, req0 is granted first.
- Counter wrap: CNT_W=2, run 5 ops -> op_count sequence 1, 2, 3, 0, 1.
